// File: rtl/counter_pkg.sv
// Shared encodings for the programmable load counter and its helpers.
package counter_pkg;

    // Run/stop FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Values of the mode input
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

    // Values of the dir input
    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/clk_prescaler.sv
// Clock prescaler: emits a one-cycle tick every (div+1) enabled cycles.
// The divisor is sampled live; a divisor lowered below the current phase
// produces a tick on the next enabled cycle rather than a long wrap.
module clk_prescaler #(
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [PRE_W-1:0] div,
    output logic             tick
);

    logic [PRE_W-1:0] phase;

    assign tick = en && (phase >= div);

    // Phase counter: cleared on reset or clr, restarts after each tick
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written only with non-blocking assignments,
        // so every register samples the pre-edge values of its inputs.
        if (rst || clr) begin
            phase <= '0;
        end else if (tick) begin
            phase <= '0;
        end else if (en) begin
            phase <= phase + 1'b1;
        end
    end

endmodule

// File: rtl/prog_load_counter.sv
// Programmable loadable up/down counter with prescaled enable, one-shot or
// auto-reload operation, a run/stop FSM, a terminal-count pulse and a
// registered zero flag.
module prog_load_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic             dir,
    input  logic [PRE_W-1:0] pre_div,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             tc,
    output logic             busy
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] reload, reload_nxt, count_nxt;
    logic [WIDTH:0]   count_inc;
    logic             tc_nxt;
    logic             tick;
    logic             pre_clr;
    logic             pre_en;
    logic             terminal;

    // A start accepted from IDLE/DONE restarts the prescaler phase so the
    // first tick lands pre_div+1 cycles after the start edge.
    assign pre_clr = load || ((state != ST_RUN) && start && !stop);
    assign pre_en  = (state == ST_RUN) && !stop;

    // One extra bit so the up-mode terminal compare cannot wrap
    assign count_inc = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};

    clk_prescaler #(.PRE_W(PRE_W)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (pre_clr),
        .en   (pre_en),
        .div  (pre_div),
        .tick (tick)
    );

    // Next-state and next-count decode, priority load > stop > start > tick
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload;
        tc_nxt     = 1'b0;
        terminal   = 1'b0;

        if (load) begin
            count_nxt  = load_val;
            reload_nxt = load_val;
            if (state == ST_DONE) begin
                state_nxt = ST_IDLE;
            end
        end else if (state == ST_RUN) begin
            if (stop) begin
                state_nxt = ST_IDLE;
            end else if (tick) begin
                if (dir == DIR_DOWN) begin
                    if ((count == '0) && (mode == MODE_RELOAD) && (reload != '0)) begin
                        count_nxt = reload;
                    end else if (count <= WIDTH'(1)) begin
                        count_nxt = '0;
                        terminal  = 1'b1;
                    end else begin
                        count_nxt = count - WIDTH'(1);
                    end
                end else begin
                    if ((count == reload) && (mode == MODE_RELOAD) && (reload != '0)) begin
                        count_nxt = '0;
                    end else if (count_inc >= {1'b0, reload}) begin
                        // Also saturates a count left above reload by a dir change
                        count_nxt = reload;
                        terminal  = 1'b1;
                    end else begin
                        count_nxt = count_inc[WIDTH-1:0];
                    end
                end
                if (terminal) begin
                    tc_nxt = 1'b1;
                    if (mode == MODE_ONESHOT) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
        end else if (start && !stop) begin
            state_nxt = ST_RUN;
        end
    end

    // FSM state, count, reload and registered flags
    always_ff @(posedge clk) begin
        // NOTE: the reload value is ordinary control state, not storage, so it
        // is reset along with everything else.
        if (rst) begin
            state  <= ST_IDLE;
            count  <= '0;
            reload <= '0;
            zero   <= 1'b1;
            tc     <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            reload <= reload_nxt;
            zero   <= (count_nxt == '0);
            tc     <= tc_nxt;
            busy   <= (state_nxt == ST_RUN);
        end
    end

endmodule

// File: tb/tb_prog_load_counter.sv
// Directed self-checking bench for prog_load_counter (WIDTH=8, PRE_W=4).
// Inputs change just after a falling edge; outputs are checked on the
// following falling edge, after the intervening rising edge has acted.
module tb_prog_load_counter;
    import counter_pkg::*;

    localparam int WIDTH = 8;
    localparam int PRE_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             mode;
    logic             dir;
    logic [PRE_W-1:0] pre_div;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             tc;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    prog_load_counter #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .dir      (dir),
        .pre_div  (pre_div),
        .count    (count),
        .zero     (zero),
        .tc       (tc),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int e_count, input bit e_zero,
                             input bit e_tc, input bit e_busy);
        check({tag, ".count"}, 32'(count), 32'(e_count));
        check({tag, ".zero"},  32'(zero),  32'(e_zero));
        check({tag, ".tc"},    32'(tc),    32'(e_tc));
        check({tag, ".busy"},  32'(busy),  32'(e_busy));
    endtask

    initial begin
        int exp3 [12];
        int exp4 [7];
        int cur;
        bit e_tc;

        exp3 = '{2, 1, 0, 3, 2, 1, 0, 3, 2, 1, 0, 3};
        exp4 = '{0, 1, 2, 3, 4, 0, 1};

        rst = 1'b1; load = 1'b0; load_val = '0; start = 1'b0; stop = 1'b0;
        mode = MODE_ONESHOT; dir = DIR_DOWN; pre_div = '0;
        cyc(); cyc();
        rst = 1'b0;
        check_out("reset", 0, 1'b1, 1'b0, 1'b0);

        // One-shot down from 5, prescale 1
        load = 1'b1; load_val = 8'd5;
        cyc();
        load = 1'b0;
        check_out("os_load", 5, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check_out("os_start", 5, 1'b0, 1'b0, 1'b1);
        for (int i = 4; i >= 1; i--) begin
            cyc();
            check_out("os_run", i, 1'b0, 1'b0, 1'b1);
        end
        cyc();
        check_out("os_term", 0, 1'b1, 1'b1, 1'b0);
        cyc();
        check_out("os_done", 0, 1'b1, 1'b0, 1'b0);

        // Auto-reload down from 3
        load = 1'b1; load_val = 8'd3; mode = MODE_RELOAD;
        cyc();
        load = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        check_out("ar_start", 3, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            cyc();
            check_out("ar_run", exp3[i], exp3[i] == 0, exp3[i] == 0, 1'b1);
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check_out("ar_stop", 3, 1'b0, 1'b0, 1'b0);

        // Auto-reload up to 4, prescale 3
        load = 1'b1; load_val = 8'd4; dir = DIR_UP; pre_div = 4'd2;
        cyc();
        load = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        check_out("up_start", 4, 1'b0, 1'b0, 1'b1);
        cur = 4;
        for (int k = 1; k <= 21; k++) begin
            cyc();
            e_tc = 1'b0;
            if (k % 3 == 0) begin
                cur  = exp4[k / 3 - 1];
                e_tc = (cur == 4);
            end
            check_out("up_run", cur, cur == 0, e_tc, 1'b1);
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check_out("up_stop", 1, 1'b0, 1'b0, 1'b0);

        // Stop / resume / simultaneous start+stop
        load = 1'b1; load_val = 8'd10; dir = DIR_DOWN; mode = MODE_ONESHOT; pre_div = '0;
        cyc();
        load = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        check_out("ss_start", 10, 1'b0, 1'b0, 1'b1);
        for (int i = 9; i >= 6; i--) begin
            cyc();
            check_out("ss_run", i, 1'b0, 1'b0, 1'b1);
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check_out("ss_stop", 6, 1'b0, 1'b0, 1'b0);
        cyc();
        check_out("ss_hold", 6, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check_out("ss_resume", 6, 1'b0, 1'b0, 1'b1);
        cyc();
        check_out("ss_tick", 5, 1'b0, 1'b0, 1'b1);
        stop = 1'b1;
        cyc();
        check_out("ss_stop2", 5, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        check_out("ss_both", 5, 1'b0, 1'b0, 1'b0);
        cyc();
        check_out("ss_idle", 5, 1'b0, 1'b0, 1'b0);

        // Load colliding with a terminal tick
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            cyc();
            check_out("ld_run", i, 1'b0, 1'b0, 1'b1);
        end
        load = 1'b1; load_val = 8'd9;
        cyc();
        load = 1'b0;
        check_out("ld_term", 9, 1'b0, 1'b0, 1'b1);
        cyc();
        check_out("ld_after", 8, 1'b0, 1'b0, 1'b1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;

        // One-shot with load value 0
        load = 1'b1; load_val = 8'd0;
        cyc();
        load = 1'b0;
        check_out("z_load", 0, 1'b1, 1'b0, 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check_out("z_start", 0, 1'b1, 1'b0, 1'b1);
        cyc();
        check_out("z_term", 0, 1'b1, 1'b1, 1'b0);
        cyc();
        check_out("z_done", 0, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of RUN
        load = 1'b1; load_val = 8'h37; mode = MODE_RELOAD;
        cyc();
        load = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        check_out("rr_run", 8'h37, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_out("rr_reset", 0, 1'b1, 1'b0, 1'b0);
        // Reload register must be cleared too: auto-reload from 0 stays at 0 with tc
        start = 1'b1;
        cyc();
        start = 1'b0;
        check_out("rr_start", 0, 1'b1, 1'b0, 1'b1);
        cyc();
        check_out("rr_tick1", 0, 1'b1, 1'b1, 1'b1);
        cyc();
        check_out("rr_tick2", 0, 1'b1, 1'b1, 1'b1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check_out("rr_stop", 0, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
